// File: rtl/sumador_serial_ctrl.sv
// sumador_serial_ctrl: bit-serial adder sequencer, LSB first, one bit per clock.
// Latches two WIDTH-bit operands on start, iterates a 1-bit full adder WIDTH
// times, then presents sum/cout with a one-cycle done pulse.
// Optional feature macro: SUMADOR_SUB_EN adds a 'sub' input (A-B via ~B and
// carry-in 1) and an 'ovf' signed-overflow output.
module sumador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SUMADOR_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SUMADOR_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  logic s_bit, c_nxt, last_bit;

  // Next-state, datapath shift and result capture; everything holds when ena=0
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SUMADOR_SUB_EN
    ovf_d    = ovf_q;
`endif
    s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));

    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // sum/cout are left alone here so the previous result stays
            // readable until the first RUN edge overwrites it.
            a_d     = op_a;
`ifdef SUMADOR_SUB_EN
            b_d     = sub ? ~op_b : op_b;
            c_d     = sub ? 1'b1 : cin;
`else
            b_d     = op_b;
            c_d     = cin;
`endif
            cnt_d   = '0;
            state_d = RUN;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        RUN: begin
          sum_d = {s_bit, sum_q[WIDTH-1:1]};
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          c_d   = c_nxt;
          cnt_d = cnt_q + CW'(1);
          if (last_bit) begin
            cout_d  = c_nxt;
`ifdef SUMADOR_SUB_EN
            // c_q is the carry into the MSB on this cycle
            ovf_d   = c_q ^ c_nxt;
`endif
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously (aborts any op)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SUMADOR_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SUMADOR_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SUMADOR_SUB_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Testbench for sumador_serial_ctrl: table vectors, random ops against an
// arithmetic reference model, plus back-to-back, stall and reset-abort cases.
module tb_sumador_serial_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ena, start, cin;
  logic [W-1:0] op_a, op_b, sum;
  logic         busy, done, cout;
`ifdef SUMADOR_SUB_EN
  logic         sub, ovf;
`endif

  int vecs = 0;
  int errs = 0;

  sumador_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUMADOR_SUB_EN
    .sub(sub), .ovf(ovf),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, b, input logic ci, input logic sb,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int unsigned bb, tot;
    int sa, sbv, tru;
    bb  = sb ? ((~b) & ((1 << W) - 1)) : b;
    tot = a + bb + (sb ? 1 : ci);
    es  = tot[W-1:0];
    ec  = tot[W];
    sa  = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sbv = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
    tru = sb ? sa - sbv : sa + sbv + ci;
    eo  = (tru < -(1 << (W - 1))) || (tru > (1 << (W - 1)) - 1);
  endtask

  // Called at a negedge; leaves the op accepted and returns at the next negedge
  task automatic accept(input logic [W-1:0] a, b, input logic ci, input logic sb);
    op_a = a; op_b = b; cin = ci; start = 1'b1;
`ifdef SUMADOR_SUB_EN
    sub = sb;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy=1; optionally scrambles start/operands during RUN
  // and stalls ena for 3 edges after 4 bits have been processed.
  task automatic wait_done(input bit toggle, input bit stall, output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (toggle) begin
        start = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      end
      if (stall && n == 5) ena = 1'b0;
      if (stall && n == 8) ena = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string nm, input int n, input int exp_n,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    chk({nm, " busy_cycles"}, n, exp_n);
    chk({nm, " done"}, done, 1);
    chk({nm, " busy_in_done"}, busy, 0);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, ec);
`ifdef SUMADOR_SUB_EN
    chk({nm, " ovf"}, ovf, eo);
`endif
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, b, input logic ci, input logic sb);
    logic [W-1:0] es; logic ec, eo; int n;
    model(a, b, ci, sb, es, ec, eo);
    accept(a, b, ci, sb);
    wait_done(1'b0, 1'b0, n);
    check_res(nm, n, W, es, ec, eo);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [W-1:0] es; logic ec, eo; int n;

    tbl[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
`ifdef SUMADOR_SUB_EN
    sub = 1'b0;
`endif
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0);
      wait_done(1'b0, 1'b0, n);
      check_res($sformatf("tbl%0d", i), n, W, tbl[i].es, tbl[i].ec, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d done_pulse", i), done, 0);
      chk($sformatf("tbl%0d idle_hold_sum", i), sum, tbl[i].es);
    end

    // Back-to-back with start held in DONE, then start toggled during RUN
    accept(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0, n);
    check_res("b2b first", n, W, 8'h30, 1'b0, 1'b0);
    op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no_idle busy", busy, 1);
    chk("b2b done_drop", done, 0);
    wait_done(1'b1, 1'b0, n);
    check_res("b2b second", n, W, 8'h10, 1'b0, 1'b0);
    @(negedge clk);

    // Stall for 3 edges at bit 4, then hold ena low while in DONE
    accept(8'hAA, 8'h55, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, n);
    check_res("stall", n, W + 3, 8'hFF, 1'b0, 1'b0);
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall done_held", done, 1);
    end
    chk("stall sum_held", sum, 8'hFF);
    ena = 1'b1;
    @(negedge clk);
    chk("stall done_drop", done, 0);

    // Asynchronous reset at bit 5 aborts immediately
    accept(8'h7E, 8'h6D, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_reset", 8'h3C, 8'hC4, 1'b0, 1'b0);

`ifdef SUMADOR_SUB_EN
    accept(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(1'b0, 1'b0, n);
    check_res("sub 05-07", n, W, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    accept(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(1'b0, 1'b0, n);
    check_res("sub 80-01", n, W, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
`endif

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb; logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SUMADOR_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rc, rs, es, ec, eo);
      do_op($sformatf("rand%0d", i), ra, rb, rc, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
